// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - slot phase constants, arbiter state encoding and strobe decode
//
// Purpose: shared definitions for vram_arbiter and vram_slot_counter.
// Ports: none (package).
// Optional feature macro: VRAM_BLANK_FREE_EN. When defined, the CPU may also
// use phases 0-3 of a slot whose latched blank is high, and no video window
// opens in that slot.
package vga_pkg;

  localparam logic [2:0] VID_FIRST       = 3'd0;
  localparam logic [2:0] VID_LAST        = 3'd2;
  localparam logic [2:0] TURN            = 3'd3;  // turnaround: idle decode leaves every strobe high
  localparam logic [2:0] CPU_START       = 3'd4;
  localparam logic [2:0] BLANK_CPU_START = 3'd0;
  localparam logic [2:0] LAST_PHASE      = 3'd7;

`ifdef VRAM_BLANK_FREE_EN
  localparam bit BLANK_FREE = 1'b1;
`else
  localparam bit BLANK_FREE = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETUP   = 3'd1,
    STROBE1 = 3'd2,
    STROBE2 = 3'd3,
    HOLD    = 3'd4
  } arb_state_e;

  // All bus controls in one bundle so the top can register them together.
  typedef struct packed {
    logic vga_oe_n;
    logic cpu_oe_n;
    logic ce_n;
    logic oe_n;
    logic we_n;
    logic ack;
  } vram_ctl_t;

  localparam vram_ctl_t CTL_IDLE = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  // Bus controls for a given cycle. A CPU access takes precedence; otherwise
  // the video window is open on its phases unless the slot is blank-free.
  function automatic vram_ctl_t decode_ctl(arb_state_e st, logic [2:0] phase,
                                           logic blank_l, logic sync, logic we);
    vram_ctl_t c;
    c = CTL_IDLE;
    if (sync) begin
      case (st)
        SETUP: begin
          c.cpu_oe_n = 1'b0;
          c.ce_n     = 1'b0;
        end
        STROBE1, STROBE2: begin
          c.cpu_oe_n = 1'b0;
          c.ce_n     = 1'b0;
          if (we) c.we_n = 1'b0;
          else    c.oe_n = 1'b0;
        end
        HOLD: begin
          c.cpu_oe_n = 1'b0;
          c.ce_n     = 1'b0;
          c.ack      = 1'b1;
        end
        default: begin
          if (((phase - VID_FIRST) <= (VID_LAST - VID_FIRST)) && !(BLANK_FREE && blank_l)) begin
            c.vga_oe_n = 1'b0;
            c.ce_n     = 1'b0;
            c.oe_n     = 1'b0;
          end
        end
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/vram_slot_counter.sv
// rtl/vram_slot_counter.sv - 8-pixel slot phase counter with sync flag and resync detect
//
// Ports:
//   pclk, rst  : pixel clock, synchronous active-high reset
//   shload_n   : slot marker, low on the last pixel of a slot
//   phase_d    : phase the next cycle will have (0 after a marker)
//   sync_d     : sync flag value for the next cycle
//   resync     : marker seen at a phase other than 7 after sync
module vram_slot_counter (
  input  logic       pclk,
  input  logic       rst,
  input  logic       shload_n,
  output logic [2:0] phase_d,
  output logic       sync_d,
  output logic       resync
);
  import vga_pkg::*;

  logic [2:0] phase_q;
  logic       sync_q;

  always_comb begin
    phase_d = shload_n ? (phase_q + 3'd1) : 3'd0;
    sync_d  = sync_q | ~shload_n;
    // The very first marker only establishes sync; it is never a resync.
    resync  = ~shload_n & sync_q & (phase_q != LAST_PHASE);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      phase_q <= 3'd0;
      sync_q  <= 1'b0;
    end else begin
      phase_q <= phase_d;
      sync_q  <= sync_d;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// rtl/vram_arbiter.sv - VRAM arbiter between video fetch and Z180 CPU accesses
//
// Ports:
//   pclk, rst          : pixel clock, synchronous active-high reset
//   shload_n, blank    : slot marker and registered blank from the timing generator
//   cpu_req, cpu_we    : CPU level request (held until ack) and write select
//   cpu_ack            : one-cycle completion pulse
//   cpu_wait_n         : Z180 WAIT, low while a request is unserved
//   vga_oe_n, cpu_oe_n : address/data buffer enables (video / CPU)
//   vram_ce_n/oe_n/we_n: SRAM strobes
// Optional feature macro: VRAM_BLANK_FREE_EN (see vga_pkg).
module vram_arbiter (
  input  logic pclk,
  input  logic rst,
  input  logic shload_n,
  input  logic blank,
  input  logic cpu_req,
  input  logic cpu_we,
  output logic cpu_ack,
  output logic cpu_wait_n,
  output logic vga_oe_n,
  output logic cpu_oe_n,
  output logic vram_ce_n,
  output logic vram_oe_n,
  output logic vram_we_n
);
  import vga_pkg::*;

  logic [2:0] phase_d;
  logic       sync_d;
  logic       resync;

  arb_state_e state_q, state_d;
  logic       blank_l_q, blank_l_d;
  logic       we_l_q, we_l_d;
  logic       acked_q, acked_d;
  logic       pending, start_phase;
  vram_ctl_t  ctl_q, ctl_d;

  vram_slot_counter u_slot (
    .pclk     (pclk),
    .rst      (rst),
    .shload_n (shload_n),
    .phase_d  (phase_d),
    .sync_d   (sync_d),
    .resync   (resync)
  );

  // Everything is computed for the upcoming cycle (phase_d) so the registered
  // outputs line up with the phase they belong to.
  always_comb begin
    blank_l_d   = shload_n ? blank_l_q : blank;
    pending     = cpu_req & ~acked_q & sync_d;
    start_phase = (phase_d == CPU_START) |
                  (BLANK_FREE & blank_l_d & (phase_d == BLANK_CPU_START));

    state_d = state_q;
    case (state_q)
      IDLE:    if (pending && start_phase) state_d = SETUP;
      SETUP:   state_d = STROBE1;
      STROBE1: state_d = STROBE2;
      STROBE2: state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // A resync drops any access in flight; the request stays pending and is
    // retried at the next start phase of the realigned slot.
    if (resync) state_d = IDLE;

    we_l_d = (state_q == IDLE && state_d == SETUP) ? cpu_we : we_l_q;

    // acked blocks a second access until the CPU has released its request.
    if (!cpu_req)              acked_d = 1'b0;
    else if (state_q == HOLD)  acked_d = 1'b1;
    else                       acked_d = acked_q;

    ctl_d = decode_ctl(state_d, phase_d, blank_l_d, sync_d, we_l_d);
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q   <= IDLE;
      blank_l_q <= 1'b1;
      we_l_q    <= 1'b0;
      acked_q   <= 1'b0;
      ctl_q     <= CTL_IDLE;
    end else begin
      state_q   <= state_d;
      blank_l_q <= blank_l_d;
      we_l_q    <= we_l_d;
      acked_q   <= acked_d;
      ctl_q     <= ctl_d;
    end
  end

  assign cpu_wait_n = ~(cpu_req & ~acked_q);
  assign cpu_ack    = ctl_q.ack;
  assign vga_oe_n   = ctl_q.vga_oe_n;
  assign cpu_oe_n   = ctl_q.cpu_oe_n;
  assign vram_ce_n  = ctl_q.ce_n;
  assign vram_oe_n  = ctl_q.oe_n;
  assign vram_we_n  = ctl_q.we_n;

endmodule

// File: tb/tb_vram_arbiter.sv
// tb/tb_vram_arbiter.sv - self-checking bench for vram_arbiter with a slot-level reference model
module tb_vram_arbiter;

  logic pclk = 1'b0;
  logic rst, shload_n, blank, cpu_req, cpu_we;
  logic cpu_ack, cpu_wait_n, vga_oe_n, cpu_oe_n, vram_ce_n, vram_oe_n, vram_we_n;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

`ifdef VRAM_BLANK_FREE_EN
  localparam bit BF = 1'b1;
`else
  localparam bit BF = 1'b0;
`endif

  // Reference model: slot phase, sync, latched blank, and the access as an
  // age (0..3) counted from its start cycle.
  int m_phase = 0;
  int m_age   = 0;
  bit m_sync = 0, m_blank_l = 1, m_acc = 0, m_we = 0, m_acked = 0;
  bit e_vga = 1, e_cpu = 1, e_ce = 1, e_oe = 1, e_we = 1, e_ack = 0;

  always #5 pclk = ~pclk;

  vram_arbiter dut (
    .pclk       (pclk),
    .rst        (rst),
    .shload_n   (shload_n),
    .blank      (blank),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_ack    (cpu_ack),
    .cpu_wait_n (cpu_wait_n),
    .vga_oe_n   (vga_oe_n),
    .cpu_oe_n   (cpu_oe_n),
    .vram_ce_n  (vram_ce_n),
    .vram_oe_n  (vram_oe_n),
    .vram_we_n  (vram_we_n)
  );

  task automatic check(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %0d want %0d", name, cyc, act, exp);
    end
  endtask

  task automatic model_step();
    bit shl, resync, was_acc, was_hold, pend, eligible;
    if (rst) begin
      m_phase = 0; m_sync = 0; m_blank_l = 1; m_acc = 0; m_age = 0; m_acked = 0;
    end else begin
      shl      = !shload_n;
      resync   = shl && m_sync && (m_phase != 7);
      was_acc  = m_acc;
      was_hold = m_acc && (m_age == 3);
      pend     = cpu_req && !m_acked;
      if (!cpu_req)      m_acked = 0;
      else if (was_hold) m_acked = 1;
      m_phase = shl ? 0 : (m_phase + 1) % 8;
      m_sync  = m_sync || shl;
      if (shl) m_blank_l = blank;
      if (m_acc) begin
        if (was_hold || resync) m_acc = 0;
        else m_age++;
      end
      eligible = (m_phase == 4) || (BF && m_blank_l && m_phase == 0);
      if (!was_acc && !resync && m_sync && pend && eligible) begin
        m_acc = 1; m_age = 0; m_we = cpu_we;
      end
    end
    e_vga = 1; e_cpu = 1; e_ce = 1; e_oe = 1; e_we = 1; e_ack = 0;
    if (m_sync) begin
      if (m_acc) begin
        e_cpu = 0; e_ce = 0;
        if (m_age == 1 || m_age == 2) begin
          if (m_we) e_we = 0; else e_oe = 0;
        end
        if (m_age == 3) e_ack = 1;
      end else if (m_phase <= 2 && !(BF && m_blank_l)) begin
        e_vga = 0; e_ce = 0; e_oe = 0;
      end
    end
  endtask

  task automatic compare();
    check("vga_oe_n", vga_oe_n, e_vga);
    check("cpu_oe_n", cpu_oe_n, e_cpu);
    check("vram_ce_n", vram_ce_n, e_ce);
    check("vram_oe_n", vram_oe_n, e_oe);
    check("vram_we_n", vram_we_n, e_we);
    check("cpu_ack", cpu_ack, e_ack);
    check("cpu_wait_n", cpu_wait_n, !(cpu_req && !m_acked));
    checks++;
    if (!vga_oe_n && !cpu_oe_n) begin
      errors++;
      $display("FAIL enable_overlap cycle %0d got vga_oe_n=%b cpu_oe_n=%b want not both 0",
               cyc, vga_oe_n, cpu_oe_n);
    end
  endtask

  task automatic step();
    @(posedge pclk);
    model_step();
    @(negedge pclk);
    cyc++;
    compare();
  endtask

  // Regular slot markers: low on the cycle whose phase is 7.
  task automatic tick();
    shload_n = (m_phase == 7) ? 1'b0 : 1'b1;
    step();
  endtask

  task automatic wait_phase(input int p);
    for (int k = 0; k < 16 && m_phase != p; k++) tick();
    checks++;
    if (m_phase != p) begin
      errors++;
      $display("FAIL wait_phase timeout got %0d want %0d", m_phase, p);
    end
  endtask

  // Steps until the DUT pulses cpu_ack (-1 if none within max); also counts
  // cycles with the CPU read strobe, write strobe and video enable active.
  task automatic run_to_ack(input int max, output int n, output int oe_c,
                            output int we_c, output int vga_c);
    n = -1; oe_c = 0; we_c = 0; vga_c = 0;
    for (int i = 1; i <= max; i++) begin
      tick();
      if (!cpu_oe_n && !vram_oe_n) oe_c++;
      if (!vram_we_n) we_c++;
      if (!vga_oe_n) vga_c++;
      if (cpu_ack) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n, oe_c, we_c, vga_c, cnt;
    rst = 1; shload_n = 1; blank = 0; cpu_req = 0; cpu_we = 0;
    step();
    step();
    check("rst_vga_oe_n", vga_oe_n, 1'b1);
    check("rst_cpu_oe_n", cpu_oe_n, 1'b1);
    check("rst_ce_n", vram_ce_n, 1'b1);
    check("rst_ack", cpu_ack, 1'b0);
    rst = 0;

    // Nothing active before the first marker, then a video window at 0-2.
    cnt = 0;
    for (int i = 0; i < 20 && !m_sync; i++) begin
      tick();
      if (!m_sync && (!vga_oe_n || !vram_ce_n)) cnt++;
    end
    check_int("pre_sync_active", cnt, 0);
    cnt = (vga_oe_n == 1'b0) ? 1 : 0;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (!vga_oe_n) cnt++;
    end
    check_int("video_window_len", cnt, 3);

    // Read requested at phase 1: SETUP at 4, oe at 5-6, ack at 7.
    wait_phase(1);
    cpu_req = 1; cpu_we = 0;
    run_to_ack(12, n, oe_c, we_c, vga_c);
    check_int("read_latency", n, 6);
    check_int("read_oe_cycles", oe_c, 2);
    tick();
    check("wait_after_ack", cpu_wait_n, 1'b1);

    // Held request gets no second access; a one-cycle release re-arms it.
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (cpu_ack) cnt++;
    end
    check_int("held_req_acks", cnt, 0);
    cpu_req = 0;
    tick();
    cpu_req = 1;
    run_to_ack(12, n, oe_c, we_c, vga_c);
    check_int("rearm_latency", n, 6);
    cpu_req = 0;
    tick();

    // Write at phase 7 into a blanked slot.
    blank = 1;
    wait_phase(7);
    cpu_req = 1; cpu_we = 1;
    run_to_ack(12, n, oe_c, we_c, vga_c);
    check_int("blank_write_latency", n, BF ? 4 : 8);
    check_int("blank_write_we_cycles", we_c, 2);
    check_int("blank_write_video", vga_c, BF ? 0 : 3);
    cpu_req = 0; blank = 0;
    tick();

    // Resync during STROBE1 aborts the write and retries it in the new slot.
    wait_phase(7);
    tick();
    cpu_req = 1; cpu_we = 1;
    wait_phase(5);
    check("strobe1_we", vram_we_n, 1'b0);
    shload_n = 0;
    step();
    check("resync_we_n", vram_we_n, 1'b1);
    check("resync_cpu_oe_n", cpu_oe_n, 1'b1);
    check("resync_ack", cpu_ack, 1'b0);
    run_to_ack(12, n, oe_c, we_c, vga_c);
    check_int("resync_retry_latency", n, 7);
    check_int("resync_retry_we_cycles", we_c, 2);
    cpu_req = 0;
    tick();

    // Reset during STROBE2 drops the access without an ack.
    cpu_req = 1; cpu_we = 0;
    wait_phase(6);
    check("strobe2_oe", vram_oe_n, 1'b0);
    rst = 1;
    step();
    rst = 0; cpu_req = 0;
    check("rst_mid_cpu_oe_n", cpu_oe_n, 1'b1);
    check("rst_mid_oe_n", vram_oe_n, 1'b1);
    check("rst_mid_ce_n", vram_ce_n, 1'b1);
    check("rst_mid_ack", cpu_ack, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cpu_ack) cnt++;
    end
    check_int("rst_no_ack", cnt, 0);

    // Randomized traffic with occasional resyncs, blank changes and resets.
    for (int i = 0; i < 4000; i++) begin
      rst = ($urandom_range(0, 599) == 0);
      shload_n = (m_phase == 7 || $urandom_range(0, 59) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 15) == 0) blank = 1'($urandom_range(0, 1));
      cpu_we = 1'($urandom_range(0, 1));
      if (!cpu_req) cpu_req = ($urandom_range(0, 3) == 0);
      else if (m_acked || e_ack) cpu_req = 1'($urandom_range(0, 1));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
